gesture_scan_ctrl: RTL

GESTURE_SCAN_CTRL -- requirements
Module: gesture_scan_ctrl

---
 rtl/gesture_scan_ctrl.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/gesture_scan_ctrl.sv
// Gesture scanner: polls five fingers through a shared detector, decodes the
// frame into a sign code, debounces it across frames and hands it off.
module gesture_scan_ctrl #(
  parameter int unsigned STABLE_CNT = 3,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  output logic       det_req,
  output logic [2:0] det_idx,
  input  logic       det_done,
  input  logic       det_status,
  output logic [4:0] pattern,
  output logic [3:0] sign_code,
  output logic       sign_valid,
  input  logic       sign_ready,
  output logic       busy,
  output logic       timeout_err
);

  localparam int unsigned IDX_W  = 3;
  localparam int unsigned PAT_W  = 5;
  localparam int unsigned CODE_W = 4;
  localparam int unsigned WAIT_W = 8;

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(4);
  localparam logic [CODE_W-1:0] CODE_NONE = CODE_W'(10);
  localparam logic [CODE_W-1:0] STAB_MAX  = CODE_W'(15);
  localparam logic [CODE_W-1:0] STAB_TGT  = CODE_W'(STABLE_CNT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_DECODE = 3'd2,
    S_STAB   = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  state_t              state, state_n;
  logic                bubble, bubble_n;
  logic [WAIT_W-1:0]   wait_cnt, wait_cnt_n;
  logic [PAT_W-1:0]    frame, frame_n;
  logic [CODE_W-1:0]   code, code_n;
  logic [CODE_W-1:0]   stab_cnt, stab_cnt_n;
  logic [CODE_W-1:0]   prev_code, prev_code_n;
  logic [CODE_W-1:0]   last_emitted, last_emitted_n;
  logic [CODE_W-1:0]   stab_upd;
  logic                capture, cap_bit;

  logic                det_req_n;
  logic [IDX_W-1:0]    det_idx_n;
  logic [PAT_W-1:0]    pattern_n;
  logic [CODE_W-1:0]   sign_code_n;
  logic                sign_valid_n;
  logic                busy_n;
  logic                timeout_err_n;

  // Frame bits are {pinky,ring,middle,index,thumb}; anything unlisted is "no sign".
  function automatic logic [CODE_W-1:0] decode_frame(input logic [PAT_W-1:0] p);
    logic [CODE_W-1:0] c;
    case (p)
      5'b00010: c = CODE_W'(1);
      5'b00110: c = CODE_W'(2);
      5'b00111: c = CODE_W'(3);
      5'b01111: c = CODE_W'(4);
      5'b11111: c = CODE_W'(5);
      5'b01110: c = CODE_W'(6);
      5'b10110: c = CODE_W'(7);
      5'b11010: c = CODE_W'(8);
      5'b11100: c = CODE_W'(9);
      default:  c = CODE_NONE;
    endcase
    return c;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble       <= 1'b0;
      wait_cnt     <= '0;
      frame        <= '0;
      code         <= '0;
      stab_cnt     <= '0;
      prev_code    <= '0;
      last_emitted <= '0;
      det_req      <= 1'b0;
      det_idx      <= '0;
      pattern      <= '0;
      sign_code    <= '0;
      sign_valid   <= 1'b0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      bubble       <= bubble_n;
      wait_cnt     <= wait_cnt_n;
      frame        <= frame_n;
      code         <= code_n;
      stab_cnt     <= stab_cnt_n;
      prev_code    <= prev_code_n;
      last_emitted <= last_emitted_n;
      det_req      <= det_req_n;
      det_idx      <= det_idx_n;
      pattern      <= pattern_n;
      sign_code    <= sign_code_n;
      sign_valid   <= sign_valid_n;
      busy         <= busy_n;
      timeout_err  <= timeout_err_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n        = state;
    bubble_n       = bubble;
    wait_cnt_n     = wait_cnt;
    frame_n        = frame;
    code_n         = code;
    stab_cnt_n     = stab_cnt;
    prev_code_n    = prev_code;
    last_emitted_n = last_emitted;
    det_idx_n      = det_idx;
    pattern_n      = pattern;
    sign_code_n    = sign_code;
    sign_valid_n   = sign_valid;
    timeout_err_n  = timeout_err;
    stab_upd       = stab_cnt;
    capture        = 1'b0;
    cap_bit        = 1'b0;

    case (state)
      S_IDLE: begin
        if (frame_start) begin
          state_n       = S_WAIT;
          det_idx_n     = '0;
          frame_n       = '0;
          timeout_err_n = 1'b0;
          bubble_n      = 1'b0;
          wait_cnt_n    = '0;
        end
      end

      S_WAIT: begin
        if (bubble) begin
          // Gap between fingers: detector results are dropped here.
          bubble_n   = 1'b0;
          wait_cnt_n = '0;
        end else begin
          if (det_done) begin
            capture = 1'b1;
            cap_bit = det_status;
          end else if (wait_cnt == WAIT_LAST) begin
            capture       = 1'b1;
            cap_bit       = 1'b0;
            timeout_err_n = 1'b1;
          end else begin
            wait_cnt_n = wait_cnt + WAIT_W'(1);
          end

          if (capture) begin
            frame_n[det_idx] = cap_bit;
            wait_cnt_n       = '0;
            if (det_idx < IDX_LAST) begin
              det_idx_n = det_idx + IDX_W'(1);
              bubble_n  = 1'b1;
            end else begin
              state_n = S_DECODE;
            end
          end
        end
      end

      S_DECODE: begin
        pattern_n = frame;
        code_n    = decode_frame(frame);
        state_n   = S_STAB;
      end

      S_STAB: begin
        if (code == prev_code) begin
          stab_upd = (stab_cnt == STAB_MAX) ? STAB_MAX : stab_cnt + CODE_W'(1);
        end else begin
          stab_upd    = CODE_W'(1);
          prev_code_n = code;
        end
        stab_cnt_n = stab_upd;
        // A "no sign" frame re-arms the last emitted gesture.
        if (code == CODE_NONE) last_emitted_n = '0;
        if (stab_upd == STAB_TGT && code != CODE_NONE && code != last_emitted) begin
          state_n      = S_HOLD;
          sign_code_n  = code;
          sign_valid_n = 1'b1;
        end else begin
          state_n = S_IDLE;
        end
      end

      S_HOLD: begin
        if (sign_ready) begin
          last_emitted_n = sign_code;
          sign_valid_n   = 1'b0;
          state_n        = S_IDLE;
        end
      end

      default: state_n = S_IDLE;
    endcase

    det_req_n = (state_n == S_WAIT) && !bubble_n;
    busy_n    = (state_n != S_IDLE);
  end

endmodule
